// File: rtl/dii_arb_pkg.sv
// rtl/dii_arb_pkg.sv - shared types and helpers for the DII packet arbiter and router selectors
package dii_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Width of a port index; kept at least 1 bit so N=1 instances still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Supports up to 32 ports; returns the highest set bit (one-hot input expected).
  function automatic int onehot2idx(input logic [31:0] onehot);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/dii_rr_select.sv
// rtl/dii_rr_select.sv - combinational rotating priority encoder, search starts at ptr
module dii_rr_select
  import dii_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int j;

  // Walk offsets from farthest to nearest so the port closest to ptr overrides.
  always_comb begin
    gnt_onehot = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt_onehot    = '0;
        gnt_onehot[j] = 1'b1;
      end
    end
  end

  assign gnt_idx = IW'(onehot2idx(32'(gnt_onehot)));
  assign any     = |req;

endmodule

// File: rtl/dii_packet_arbiter.sv
// rtl/dii_packet_arbiter.sv - packet-level round-robin merge of N DII streams onto one link
// Per-port completed-packet counters are built only when DII_ARB_STATS_EN is defined.
module dii_packet_arbiter
  import dii_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_last,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         grant,
  output logic                 busy,
  output logic [N*CNTW-1:0]    pkt_count
);

  localparam int IW = idx_width(N);

  arb_state_e    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [N-1:0]  sel_gnt;
  logic [IW-1:0] sel_idx;
  logic          sel_any;
  logic          last_accept;

  dii_rr_select #(.N(N), .IW(IW)) u_select (
    .req        (in_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (sel_gnt),
    .gnt_idx    (sel_idx),
    .any        (sel_any)
  );

  assign last_accept = (state == BUSY) && out_valid && out_ready && out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      grant  <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            grant <= sel_gnt;
            owner <= sel_idx;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (last_accept) begin
            grant  <= '0;
            busy   <= 1'b0;
            state  <= IDLE;
            rr_ptr <= (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // grant is zero outside BUSY, so the pass-through mux idles by itself.
  always_comb begin
    out_data  = '0;
    out_last  = 1'b0;
    out_valid = 1'b0;
    in_ready  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        out_data    = in_data[i*WIDTH +: WIDTH];
        out_last    = in_last[i];
        out_valid   = in_valid[i];
        in_ready[i] = out_ready;
      end
    end
  end

`ifdef DII_ARB_STATS_EN
  logic [CNTW-1:0] cnt [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (last_accept && grant[i]) cnt[i] <= cnt[i] + CNTW'(1);
      end
    end
  end

  always_comb begin
    pkt_count = '0;
    for (int i = 0; i < N; i++) pkt_count[i*CNTW +: CNTW] = cnt[i];
  end
`else
  assign pkt_count = '0;
`endif

endmodule
